// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode encodings, default widths, reserved-mode test.
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_NOT   = 4'b0101,
    ALU_SLL   = 4'b0110,
    ALU_SLA   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_ADDS2 = 4'b1010
  } alu_mode_e;

  localparam logic [3:0] ALU_MODE_MAX = 4'b1010;

  // Codes above the last defined mode are reserved.
  function automatic logic mode_reserved(input logic [3:0] m);
    return m > ALU_MODE_MAX;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority operand resolver: r0, retiring ALU result, forward latch, register file.
module operand_fwd_mux #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  retire_wr,
  input  logic [REG_ADDR_W-1:0] retire_rd,
  input  logic [DATA_W-1:0]     retire_data,
  input  logic                  fvalid,
  input  logic [REG_ADDR_W-1:0] fdest,
  input  logic [DATA_W-1:0]     fdata,
  output logic [DATA_W-1:0]     result
);

  // First match wins; the retiring result beats the latch so same-edge updates are never stale.
  always_comb begin
    result = reg_data;
    if (src == '0)
      result = '0;
    else if (retire_wr && retire_rd == src)
      result = retire_data;
    else if (fvalid && fdest == src)
      result = fdata;
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-issue stage: resolves operands, holds one instruction driving the ALU,
// latches the last retiring result for forwarding, counts issued instructions.
module alu_issue #(
  parameter int DATA_W     = alu_pkg::DATA_W,
  parameter int REG_ADDR_W = alu_pkg::REG_ADDR_W,
  parameter int IMM_W      = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_mode,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic [DATA_W-1:0]     in_rs_data,
  input  logic [DATA_W-1:0]     in_rt_data,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic                  in_use_imm,
  input  logic                  in_wr,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     operand1,
  output logic [DATA_W-1:0]     operand2,
  output logic [3:0]            mode,
  output logic                  en,
  input  logic [DATA_W-1:0]     alu_result,
  output logic                  out_wr,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  illegal,
  output logic [CNT_W-1:0]      issued_count
);
  import alu_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0]     op1;
    logic [DATA_W-1:0]     op2;
    logic [3:0]            mode;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  ill;
  } ereg_t;

  logic                  e_valid;
  ereg_t                 e_q;
  logic                  f_valid;
  logic [REG_ADDR_W-1:0] f_dest;
  logic [DATA_W-1:0]     f_data;
  logic                  in_fire, out_fire, retire_wr;
  logic [DATA_W-1:0]     rs_val, rt_val, imm_ext;

  assign in_ready  = ~e_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = e_valid & out_ready;
  assign retire_wr = out_fire & out_wr;
  assign imm_ext   = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rs_mux (
    .src(in_rs), .reg_data(in_rs_data),
    .retire_wr(retire_wr), .retire_rd(out_rd), .retire_data(alu_result),
    .fvalid(f_valid), .fdest(f_dest), .fdata(f_data), .result(rs_val)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rt_mux (
    .src(in_rt), .reg_data(in_rt_data),
    .retire_wr(retire_wr), .retire_rd(out_rd), .retire_data(alu_result),
    .fvalid(f_valid), .fdest(f_dest), .fdata(f_data), .result(rt_val)
  );

  // Output register: load on accept, empty on retire with nothing behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid <= 1'b0;
      e_q     <= '0;
    end else if (in_fire) begin
      e_valid  <= 1'b1;
      e_q.op1  <= rs_val;
      e_q.op2  <= in_use_imm ? imm_ext : rt_val;
      e_q.mode <= in_mode;
      e_q.rd   <= in_rd;
      e_q.wr   <= in_wr;
      e_q.ill  <= mode_reserved(in_mode);
    end else if (out_fire) begin
      e_valid <= 1'b0;
    end
  end

  // Forward latch: remember the last real register write that retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_valid <= 1'b0;
      f_dest  <= '0;
      f_data  <= '0;
    end else if (retire_wr && out_rd != '0) begin
      f_valid <= 1'b1;
      f_dest  <= out_rd;
      f_data  <= alu_result;
    end
  end

  // Issue counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          issued_count <= '0;
    else if (in_fire) issued_count <= issued_count + 1'b1;
  end

  assign out_valid = e_valid;
  assign operand1  = e_q.op1;
  assign operand2  = e_q.op2;
  assign mode      = e_q.mode;
  assign out_rd    = e_q.rd;
  assign illegal   = e_valid & e_q.ill;
  assign en        = e_valid & ~e_q.ill;
  assign out_wr    = e_valid & e_q.wr & ~e_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: vector table for the streaming path, hand
// sequences for stall, reserved mode and reset in the middle of a stall.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_mode;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_rs_data, in_rt_data;
  logic [15:0] in_imm;
  logic        in_use_imm, in_wr;
  logic        out_valid, out_ready;
  logic [31:0] operand1, operand2, alu_result;
  logic [3:0]  mode;
  logic        en, out_wr, illegal;
  logic [4:0]  out_rd;
  logic [31:0] issued_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_rs(in_rs), .in_rt(in_rt),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_wr(in_wr), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand1(operand1), .operand2(operand2), .mode(mode), .en(en),
    .alu_result(alu_result), .out_wr(out_wr), .out_rd(out_rd),
    .illegal(illegal), .issued_count(issued_count)
  );

  typedef struct {
    logic [3:0]  mode;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic        ui, wr;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] x_op1, x_op2;
    logic        x_en, x_wr;
    logic [31:0] x_cnt;
  } vec_t;

  vec_t vt[7];

  function automatic vec_t mk(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                              input logic ui, input logic wr, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] xo1, input logic [31:0] xo2,
                              input logic xen, input logic xwr, input logic [31:0] xcnt);
    vec_t v;
    v.mode = m; v.rs = rs; v.rt = rt; v.rsd = rsd; v.rtd = rtd; v.imm = imm;
    v.ui = ui; v.wr = wr; v.rd = rd; v.alu = alu;
    v.x_op1 = xo1; v.x_op2 = xo2; v.x_en = xen; v.x_wr = xwr; v.x_cnt = xcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input vec_t x, input logic ordy);
    in_valid = v; in_mode = x.mode; in_rs = x.rs; in_rt = x.rt;
    in_rs_data = x.rsd; in_rt_data = x.rtd; in_imm = x.imm;
    in_use_imm = x.ui; in_wr = x.wr; in_rd = x.rd;
    out_ready = ordy; alu_result = x.alu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t h;
    vec_t idle;
    idle = mk(4'h0, 5'd0, 5'd0, 0, 0, 16'h0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0);
    // mode rs rt rsd rtd imm ui wr rd | alu(retiring) | exp op1 op2 en out_wr cnt
    vt[0] = mk(4'h0, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0, 0, 1, 5'd3, 32'h0,
               32'd5, 32'd7, 1, 1, 32'd1);                      // ADD r3=r1+r2
    vt[1] = mk(4'h1, 5'd3, 5'd0, 32'h0, 32'h0, 16'hFFFF, 1, 1, 5'd4, 32'd12,
               32'd12, 32'hFFFF_FFFF, 1, 1, 32'd2);             // SUB r4=r3-(-1), b2b
    vt[2] = mk(4'h2, 5'd1, 5'd2, 32'hF0, 32'h3C, 16'h0, 0, 0, 5'd6, 32'd13,
               32'hF0, 32'h3C, 1, 0, 32'd3);                    // AND, no write
    vt[3] = mk(4'h3, 5'd4, 5'd3, 32'h0, 32'h99, 16'h0, 0, 1, 5'd5, 32'h30,
               32'd13, 32'h99, 1, 1, 32'd4);                    // r4 from latch
    vt[4] = mk(4'h4, 5'd0, 5'd0, 32'h11, 32'h22, 16'h0, 0, 1, 5'd0, 32'hBB,
               32'h0, 32'h0, 1, 1, 32'd5);                      // r0 reads zero
    vt[5] = mk(4'h0, 5'd0, 5'd5, 32'h77, 32'h01, 16'h0, 0, 1, 5'd7, 32'h55,
               32'h0, 32'hBB, 1, 1, 32'd6);                     // r0 pending write
    vt[6] = mk(4'h6, 5'd5, 5'd0, 32'h0, 32'h0, 16'h0004, 1, 1, 5'd1, 32'hCC,
               32'hBB, 32'h4, 1, 1, 32'd7);                     // latch kept past rd=0

    // Reset state
    rst = 1'b1;
    drive(1'b0, idle, 1'b1);
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_en", {31'b0, en}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_count", issued_count, 0);
    chk("rst_operand1", operand1, 0);
    rst = 1'b0;
    tick();

    // Streaming vectors at one instruction per cycle
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vt[i], 1'b1);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 1);
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 1);
      chk($sformatf("v%0d_op1", i), operand1, vt[i].x_op1);
      chk($sformatf("v%0d_op2", i), operand2, vt[i].x_op2);
      chk($sformatf("v%0d_mode", i), {28'b0, mode}, {28'b0, vt[i].mode});
      chk($sformatf("v%0d_en", i), {31'b0, en}, {31'b0, vt[i].x_en});
      chk($sformatf("v%0d_out_wr", i), {31'b0, out_wr}, {31'b0, vt[i].x_wr});
      chk($sformatf("v%0d_out_rd", i), {27'b0, out_rd}, {27'b0, vt[i].rd});
      chk($sformatf("v%0d_illegal", i), {31'b0, illegal}, 0);
      chk($sformatf("v%0d_count", i), issued_count, vt[i].x_cnt);
    end

    // Stall: E holds the SLL (op1=0xBB, op2=4) for three cycles
    h = mk(4'h9, 5'd1, 5'd0, 32'h0, 32'h0, 16'h0, 0, 1, 5'd8, 32'hDD, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, h, 1'b0);
      #1;
      chk($sformatf("stall%0d_in_ready", i), {31'b0, in_ready}, 0);
      tick();
      chk($sformatf("stall%0d_valid", i), {31'b0, out_valid}, 1);
      chk($sformatf("stall%0d_op1", i), operand1, 32'hBB);
      chk($sformatf("stall%0d_mode", i), {28'b0, mode}, 32'h6);
      chk($sformatf("stall%0d_count", i), issued_count, 32'd7);
    end
    // Release: SRA r8 reads r1 straight from the retiring SLL result
    drive(1'b1, h, 1'b1);
    tick();
    chk("release_op1", operand1, 32'hDD);
    chk("release_mode", {28'b0, mode}, 32'h9);
    chk("release_count", issued_count, 32'd8);
    h = mk(4'h8, 5'd9, 5'd1, 32'h40, 32'h0, 16'h0, 0, 1, 5'd9, 32'h1F, 0, 0, 0, 0, 0);
    drive(1'b1, h, 1'b1);
    tick();
    chk("next_op1", operand1, 32'h40);
    chk("next_op2_latch", operand2, 32'hDD);
    chk("next_count", issued_count, 32'd9);

    // Reserved mode 1100 while SRL r9 retires (latch becomes r9=0x10)
    h = mk(4'hC, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0, 0, 1, 5'd2, 32'h10, 0, 0, 0, 0, 0);
    drive(1'b1, h, 1'b1);
    tick();
    chk("ill_illegal", {31'b0, illegal}, 1);
    chk("ill_en", {31'b0, en}, 0);
    chk("ill_out_wr", {31'b0, out_wr}, 0);
    chk("ill_valid", {31'b0, out_valid}, 1);
    chk("ill_count", issued_count, 32'd10);
    // Retire it: its result must neither forward to r2 nor disturb the latch
    h = mk(4'h0, 5'd2, 5'd9, 32'h123, 32'h0, 16'h0, 0, 1, 5'd10, 32'hEEE, 0, 0, 0, 0, 0);
    drive(1'b1, h, 1'b1);
    tick();
    chk("after_ill_op1", operand1, 32'h123);
    chk("after_ill_op2_latch", operand2, 32'h10);
    chk("after_ill_illegal", {31'b0, illegal}, 0);
    chk("after_ill_en", {31'b0, en}, 1);

    // Reset in the middle of a stall, asynchronously
    drive(1'b0, idle, 1'b0);
    tick();
    chk("pre_rst_valid", {31'b0, out_valid}, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 0);
    chk("midrst_en", {31'b0, en}, 0);
    chk("midrst_count", issued_count, 0);
    chk("midrst_in_ready", {31'b0, in_ready}, 1);
    chk("midrst_operand1", operand1, 0);
    tick();
    rst = 1'b0;
    // Latch cleared: r9 now comes from the register file
    h = mk(4'h0, 5'd9, 5'd0, 32'h5, 32'h0, 16'h0, 0, 1, 5'd11, 32'h0, 0, 0, 0, 0, 0);
    drive(1'b1, h, 1'b1);
    tick();
    chk("postrst_op1", operand1, 32'h5);
    chk("postrst_count", issued_count, 32'd1);

    drive(1'b0, idle, 1'b1);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
